// File: rtl/instr_fetch_unit_if.sv
// Signal bundle between the fetch unit, the instruction ROM, branch resolution and decode.
// The master modport is the fetch unit's side; the slave modport is the surrounding pipeline's side.
interface instr_fetch_unit_if;
  logic [31:0] imem_addr;
  logic [31:0] imem_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        out_valid;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
  logic        out_ready;

  modport master (
    output imem_addr,
    input  imem_data,
    input  redirect_valid,
    input  redirect_pc,
    output out_valid,
    output out_instr,
    output out_pc,
    input  out_ready
  );

  modport slave (
    input  imem_addr,
    output imem_data,
    output redirect_valid,
    output redirect_pc,
    input  out_valid,
    input  out_instr,
    input  out_pc,
    output out_ready
  );
endinterface

// File: rtl/instr_fetch_unit.sv
// Fetch stage: PC register driving a combinational ROM, plus a small {pc, instr} prefetch FIFO toward decode.
// Optional IFU_PERF_EN adds free-running perf_fetched / perf_stalls counters.
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic                   clk,
  input  logic                   reset_n,
  instr_fetch_unit_if.master     bus
`ifdef IFU_PERF_EN
  ,
  output logic [31:0]            perf_fetched,
  output logic [31:0]            perf_stalls
`endif
);
  localparam int            PW      = $clog2(FIFO_DEPTH);
  localparam logic [PW:0]   DEPTH_C = (PW + 1)'(FIFO_DEPTH);

  logic [31:0]   r_pc;
  logic [31:0]   r_fifo_pc    [FIFO_DEPTH];
  logic [31:0]   r_fifo_instr [FIFO_DEPTH];
  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic [PW:0]   r_count;

  logic w_valid;
  logic w_full;
  logic w_pop;
  logic w_push;

  assign w_valid = (r_count != '0);
  assign w_full  = (r_count == DEPTH_C);
  assign w_pop   = w_valid & bus.out_ready;
  // A pop frees a slot in the same cycle, so a full FIFO can still fetch.
  assign w_push  = ~bus.redirect_valid & (~w_full | w_pop);

  assign bus.imem_addr = r_pc;
  assign bus.out_valid = w_valid;
  assign bus.out_instr = r_fifo_instr[r_rd_ptr];
  assign bus.out_pc    = r_fifo_pc[r_rd_ptr];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_pc     <= RESET_PC;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        r_fifo_pc[i]    <= '0;
        r_fifo_instr[i] <= '0;
      end
    end else if (bus.redirect_valid) begin
      // Flush wins over any pop this cycle; decode already holds the popped word.
      r_pc     <= {bus.redirect_pc[31:2], 2'b00};
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_fifo_pc[r_wr_ptr]    <= r_pc;
        r_fifo_instr[r_wr_ptr] <= bus.imem_data;
        r_wr_ptr               <= r_wr_ptr + 1'b1;
        r_pc                   <= r_pc + 32'd4;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

`ifdef IFU_PERF_EN
  logic [31:0] r_perf_fetched;
  logic [31:0] r_perf_stalls;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_perf_fetched <= '0;
      r_perf_stalls  <= '0;
    end else begin
      if (w_push) begin
        r_perf_fetched <= r_perf_fetched + 32'd1;
      end
      if (w_full & ~w_pop & ~bus.redirect_valid) begin
        r_perf_stalls <= r_perf_stalls + 32'd1;
      end
    end
  end

  assign perf_fetched = r_perf_fetched;
  assign perf_stalls  = r_perf_stalls;
`endif
endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: streaming, back-pressure, redirects, async reset and PC wrap.
// ROM model: word at byte address A is {16'hDEAD, A[17:2]}.
module tb_instr_fetch_unit;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;

  always #5 clk = ~clk;

  instr_fetch_unit_if ifc ();

`ifdef IFU_PERF_EN
  logic [31:0] perf_fetched;
  logic [31:0] perf_stalls;
`endif

  instr_fetch_unit #(
    .RESET_PC   (32'h0000_0000),
    .FIFO_DEPTH (2)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .bus          (ifc)
`ifdef IFU_PERF_EN
    ,
    .perf_fetched (perf_fetched),
    .perf_stalls  (perf_stalls)
`endif
  );

  always_comb ifc.imem_data = {16'hDEAD, ifc.imem_addr[17:2]};

  function automatic logic [31:0] rom_word(input logic [31:0] addr);
    return {16'hDEAD, addr[17:2]};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    $display("cyc=%0d rst_n=%0b addr=%h valid=%0b pc=%h instr=%h ready=%0b redir=%0b",
             cyc, reset_n, ifc.imem_addr, ifc.out_valid, ifc.out_pc, ifc.out_instr,
             ifc.out_ready, ifc.redirect_valid);
  endtask

  task automatic chk_head(input string tag, input logic [31:0] pc);
    chk({tag, "_valid"}, {31'd0, ifc.out_valid}, 32'd1);
    chk({tag, "_pc"}, ifc.out_pc, pc);
    chk({tag, "_instr"}, ifc.out_instr, rom_word(pc));
  endtask

  initial begin
    ifc.redirect_valid = 1'b0;
    ifc.redirect_pc    = 32'h0;
    ifc.out_ready      = 1'b1;
    reset_n            = 1'b0;
    step();
    step();

    // Reset state
    chk("rst_valid", {31'd0, ifc.out_valid}, 32'd0);
    chk("rst_pc", ifc.out_pc, 32'h0);
    chk("rst_instr", ifc.out_instr, 32'h0);
    chk("rst_addr", ifc.imem_addr, 32'h0);

    // Streaming with out_ready=1: one instruction per cycle from cycle 1
    reset_n = 1'b1;
    chk("c0_valid", {31'd0, ifc.out_valid}, 32'd0);
    for (int i = 0; i < 4; i++) begin
      step();
      chk_head("stream", 32'(i * 4));
    end

    // Asynchronous reset mid-stream, away from the clock edge
    #3;
    reset_n = 1'b0;
    #1;
    chk("arst_valid", {31'd0, ifc.out_valid}, 32'd0);
    chk("arst_addr", ifc.imem_addr, 32'h0);

    // Back-pressure for 5 cycles after release
    ifc.out_ready = 1'b0;
    step();
    reset_n = 1'b1;
    for (int c = 1; c <= 5; c++) begin
      step();
      chk_head("hold", 32'h0);
      if (c >= 2) chk("hold_addr", ifc.imem_addr, 32'h8);
    end
`ifdef IFU_PERF_EN
    chk("perf_stalls", perf_stalls, 32'd3);
    chk("perf_fetched", perf_fetched, 32'd2);
`endif
    ifc.out_ready = 1'b1;
    step();
    chk_head("drain4", 32'h4);
    step();
    chk_head("drain8", 32'h8);

    // Full FIFO then redirect to 0x20
    ifc.out_ready = 1'b0;
    step();
    chk_head("full", 32'h8);
    chk("full_addr", ifc.imem_addr, 32'h10);
    ifc.redirect_valid = 1'b1;
    ifc.redirect_pc    = 32'h20;
    step();
    ifc.redirect_valid = 1'b0;
    chk("redir_valid", {31'd0, ifc.out_valid}, 32'd0);
    chk("redir_addr", ifc.imem_addr, 32'h20);
    step();
    chk_head("redir_tgt", 32'h20);

    // Unaligned redirect target: low bits dropped
    ifc.redirect_valid = 1'b1;
    ifc.redirect_pc    = 32'h23;
    ifc.out_ready      = 1'b1;
    step();
    ifc.redirect_valid = 1'b0;
    chk("unal_addr", ifc.imem_addr, 32'h20);
    chk("unal_valid", {31'd0, ifc.out_valid}, 32'd0);
    step();
    chk_head("unal_tgt", 32'h20);

    // Redirect coinciding with an accepted pop of pc=0x4
    reset_n = 1'b0;
    step();
    reset_n = 1'b1;
    step();
    chk_head("pop0", 32'h0);
    step();
    chk_head("pop4", 32'h4);
    ifc.redirect_valid = 1'b1;
    ifc.redirect_pc    = 32'h40;
    step();
    ifc.redirect_valid = 1'b0;
    chk("pr_valid", {31'd0, ifc.out_valid}, 32'd0);
    step();
    chk_head("pr_tgt", 32'h40);
    step();
    chk_head("pr_next", 32'h44);

    // PC wrap at the top of the address space
    ifc.redirect_valid = 1'b1;
    ifc.redirect_pc    = 32'hFFFF_FFFE;
    step();
    ifc.redirect_valid = 1'b0;
    chk("wrap_addr", ifc.imem_addr, 32'hFFFF_FFFC);
    step();
    chk_head("wrap_top", 32'hFFFF_FFFC);
    step();
    chk_head("wrap_zero", 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
